// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// dmem_arb_pkg : shared constants for the two-port data-memory arbiter
// Revision     : 1.0
// ============================================================================
package dmem_arb_pkg;

    localparam int unsigned MEM_WORDS_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Misaligned or past the last word of the attached memory.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
// dmem_rr_pick : two-requester round-robin winner selection (combinational)
// Revision     : 1.0
// ============================================================================
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic winner_o
);

    assign valid_o  = req0_i | req1_i;
    // On a tie the port that did not win last time goes first.
    assign winner_o = (req0_i & req1_i) ? ~last_i : (req1_i ? PORT1 : PORT0);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : two-port round-robin arbiter in front of a word data memory
// Revision     : 1.0
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rdata_i
);

    logic [1:0]  state_q, state_d;
    logic        last_q;
    logic        id_q;
    logic        we_q;
    logic        bad_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        pick_valid;
    logic        pick_winner;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        grant;
    logic        in_access;

    dmem_rr_pick u_pick (
        .req0_i   (req0_i),
        .req1_i   (req1_i),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    assign sel_we    = (pick_winner == PORT1) ? we1_i    : we0_i;
    assign sel_addr  = (pick_winner == PORT1) ? addr1_i  : addr0_i;
    assign sel_wdata = (pick_winner == PORT1) ? wdata1_i : wdata0_i;
    assign grant     = (state_q == ST_IDLE) && pick_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= PORT1;
            id_q    <= PORT0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                id_q    <= pick_winner;
                last_q  <= pick_winner;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                bad_q   <= addr_bad(sel_addr, MEM_WORDS);
            end
            // Result captured as ACCESS ends; stores and bad accesses return zero.
            if (state_q == ST_ACCESS) begin
                rdata_q <= (we_q || bad_q) ? '0 : mem_rdata_i;
                err_q   <= bad_q;
            end
        end
    end

    assign in_access   = (state_q == ST_ACCESS);
    assign mem_re_o    = in_access && !we_q && !bad_q;
    assign mem_we_o    = in_access &&  we_q && !bad_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign ack0_o  = (state_q == ST_RESP) && (id_q == PORT0);
    assign ack1_o  = (state_q == ST_RESP) && (id_q == PORT1);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 8, giving the number of 32-bit words in the attached data memory (32 bytes).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports req0_i/req1_i, input, 1 bit each: access request from port 0 (CPU MEM stage) and port 1 (loader).
REQ-005 SHALL have ports we0_i/we1_i, input, 1 bit each: 1 = store word (sw), 0 = load word (lw).
REQ-006 SHALL have ports addr0_i/addr1_i, input, 32 bits each: byte address.
REQ-007 SHALL have ports wdata0_i/wdata1_i, input, 32 bits each: store data.
REQ-008 SHALL have ports ack0_o/ack1_o, output, 1 bit each: one-cycle completion pulse.
REQ-009 SHALL have ports rdata_o (output, 32 bits: load result, valid with ack) and err_o (output, 1 bit: bad address, valid with ack).
REQ-010 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have ports mem_addr_o, mem_wdata_o (output, 32 bits each), mem_re_o, mem_we_o (output, 1 bit each), mem_rdata_i (input, 32 bits): memory side; memory read is combinational.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, RESP: IDLE->ACCESS when any req is high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-013 SHALL, in IDLE with any req high, select a winner and latch its port id, we, addr and wdata.
REQ-014 SHALL grant the only requester when exactly one req is high.
REQ-015 SHALL, when both reqs are high, grant the port not granted last (round-robin); last-grant resets to 1, so port 0 wins the first tie.
REQ-016 SHALL, in ACCESS, drive mem_addr_o/mem_wdata_o from the latched values, assert mem_we_o=we or mem_re_o=!we (never both), and register mem_rdata_i at the cycle end.
REQ-017 SHALL hold mem_re_o and mem_we_o at 0 in IDLE and RESP; mem_addr_o and mem_wdata_o hold their last values.
REQ-018 SHALL, in RESP, pulse the winner's ack for exactly one cycle with rdata_o and err_o valid; the loser's ack stays 0.
REQ-019 SHALL hold rdata_o stable until the next RESP; it is 0 after a store.
REQ-020 SHALL treat an address as bad if addr[1:0]!=0 or addr>>2 >= MEM_WORDS; a bad access asserts no memory strobe in ACCESS and returns err_o=1, rdata_o=0.
REQ-021 SHALL have fixed latency: request sampled in IDLE at cycle N -> ack in cycle N+2; maximum throughput 1 transaction per 3 cycles.
REQ-022 Requesters SHALL hold req/we/addr/wdata stable until ack and drop req in the cycle after ack; the block ignores input changes outside IDLE.
REQ-023 SHALL keep a losing request pending without loss; it is granted on the next IDLE.

Reset
REQ-024 SHALL, while rst_i=0, immediately force state=IDLE, ack0_o=ack1_o=0, mem_re_o=mem_we_o=0, err_o=0, busy_o=0, rdata_o=0, mem_addr_o=mem_wdata_o=0, last-grant=1.
REQ-025 SHALL abort any in-flight transaction on reset, with no ack issued; the requester re-requests after reset.

Structure
REQ-026 SHALL place the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), the port-id constants and the MEM_WORDS default in shared package dmem_arb_pkg.
REQ-027 SHALL implement winner selection in one combinational sub-module, dmem_rr_pick (inputs: req0, req1, last; outputs: valid, winner); everything else stays in dmem_arbiter.

Verification
REQ-028 Single store then load: port 0 sw addr=0x8 data=0xDEADBEEF, then lw addr=0x8 -> ack0 two cycles after each sample, mem_we_o one cycle, rdata_o=0xDEADBEEF, err_o=0.
REQ-029 Tie: req0 and req1 both asserted from reset -> port 0 served first (ack0), port 1 next (ack1, 3 cycles later); repeated tie alternates 1,0.
REQ-030 Bad address: lw addr=0x6 and lw addr=0x20 -> no mem_re_o pulse, ack with err_o=1, rdata_o=0.
REQ-031 Boundary: sw/lw addr=0x1C (word 7) with data 0x12345678 -> err_o=0, readback 0x12345678.
REQ-032 Reset mid-operation: drive rst_i low during ACCESS -> strobes drop in the same cycle, no ack; after release, state IDLE and port 0 wins the next tie.
REQ-033 Stability: a store sets mem_we_o high for exactly one cycle, never together with mem_re_o; a later store leaves rdata_o=0.
